// File: rtl/score_keeper.sv
// score_keeper: turns ball-logic goal events into two-digit BCD scores per player,
// drives the goal banner code for a fixed number of video frames (freezing play),
// and latches game-over/winner until a new game is requested.
//
// Ports:
//   clk           system (pixel-domain) clock
//   reset_n       asynchronous active-low reset
//   refresh_tick  one-clk pulse per video frame
//   p1_scored     P1 goal event (rising edge counts)
//   p2_scored     P2 goal event (rising edge counts)
//   new_game      one-clk request to clear scores and restart play
//   p1_dig0/1     P1 score ones/tens BCD digit
//   p2_dig0/1     P2 score ones/tens BCD digit
//   goal          banner code: 00 none, 01 P1 goal, 10 P2 goal
//   freeze        high while banner shown or game over
//   game_over     high in the over state
//   winner        01 P1 won, 10 P2 won, 00 no winner yet
module score_keeper #(
  parameter int unsigned GOAL_FRAMES = 120,
  parameter int unsigned WIN_SCORE   = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refresh_tick,
  input  logic       p1_scored,
  input  logic       p2_scored,
  input  logic       new_game,
  output logic [3:0] p1_dig0,
  output logic [3:0] p1_dig1,
  output logic [3:0] p2_dig0,
  output logic [3:0] p2_dig1,
  output logic [1:0] goal,
  output logic       freeze,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] StPlay = 2'd0;
  localparam logic [1:0] StGoal = 2'd1;
  localparam logic [1:0] StOver = 2'd2;

  localparam logic [7:0] CntLoad = 8'(GOAL_FRAMES - 1);
  localparam logic [7:0] WinBcd  = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] p1_score_q, p1_score_d;  // {tens, ones}
  logic [7:0] p2_score_q, p2_score_d;
  logic [1:0] goal_q, goal_d;
  logic       freeze_q, freeze_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic       p1_prev_q, p2_prev_q;
  logic       p1_ev, p2_ev;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign p1_ev = p1_scored & ~p1_prev_q;
  assign p2_ev = p2_scored & ~p2_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    goal_d      = goal_q;
    freeze_d    = freeze_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    if (new_game) begin
      // Overrides any event in the same cycle.
      state_d     = StPlay;
      cnt_d       = 8'd0;
      p1_score_d  = 8'd0;
      p2_score_d  = 8'd0;
      goal_d      = 2'b00;
      freeze_d    = 1'b0;
      game_over_d = 1'b0;
      winner_d    = 2'b00;
    end else begin
      case (state_q)
        StPlay: begin
          // P1 has priority; a simultaneous P2 event earns nothing.
          if (p1_ev) begin
            p1_score_d = bcd_inc(p1_score_q);
            goal_d     = 2'b01;
            freeze_d   = 1'b1;
            cnt_d      = CntLoad;
            state_d    = StGoal;
          end else if (p2_ev) begin
            p2_score_d = bcd_inc(p2_score_q);
            goal_d     = 2'b10;
            freeze_d   = 1'b1;
            cnt_d      = CntLoad;
            state_d    = StGoal;
          end
        end
        StGoal: begin
          if (refresh_tick) begin
            if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
            end else begin
              goal_d = 2'b00;
              if ((p1_score_q == WinBcd) || (p2_score_q == WinBcd)) begin
                state_d     = StOver;
                game_over_d = 1'b1;
                winner_d    = goal_q;  // banner code identifies the scorer
              end else begin
                state_d  = StPlay;
                freeze_d = 1'b0;
              end
            end
          end
        end
        StOver: begin
          state_d = StOver;
        end
        default: begin
          state_d = StPlay;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPlay;
      cnt_q       <= 8'd0;
      p1_score_q  <= 8'd0;
      p2_score_q  <= 8'd0;
      goal_q      <= 2'b00;
      freeze_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      p1_prev_q   <= 1'b0;
      p2_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      goal_q      <= goal_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      p1_prev_q   <= p1_scored;
      p2_prev_q   <= p2_scored;
    end
  end

  assign p1_dig0   = p1_score_q[3:0];
  assign p1_dig1   = p1_score_q[7:4];
  assign p2_dig0   = p2_score_q[3:0];
  assign p2_dig1   = p2_score_q[7:4];
  assign goal      = goal_q;
  assign freeze    = freeze_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random stimulus,
// all compared against an integer-score behavioural model.
module tb_score_keeper;

  localparam int GF  = 120;
  localparam int WIN = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       refresh_tick = 1'b0;
  logic       p1_scored = 1'b0;
  logic       p2_scored = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] p1_dig0, p1_dig1, p2_dig0, p2_dig1;
  logic [1:0] goal;
  logic       freeze;
  logic       game_over;
  logic [1:0] winner;

  int n_vec = 0;
  int n_bad = 0;

  score_keeper #(.GOAL_FRAMES(GF), .WIN_SCORE(WIN)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .refresh_tick (refresh_tick),
    .p1_scored    (p1_scored),
    .p2_scored    (p2_scored),
    .new_game     (new_game),
    .p1_dig0      (p1_dig0),
    .p1_dig1      (p1_dig1),
    .p2_dig0      (p2_dig0),
    .p2_dig1      (p2_dig1),
    .goal         (goal),
    .freeze       (freeze),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  logic [21:0] dut_vec;
  assign dut_vec = {p1_dig1, p1_dig0, p2_dig1, p2_dig0, goal, freeze, game_over, winner};

  // Behavioural model: plain integer scores and a banner frame budget.
  int m_p1, m_p2, m_goal, m_winner, m_frames_left;
  bit m_freeze, m_over, m_in_banner, m_prev1, m_prev2;

  function automatic logic [21:0] exp_vec();
    return {4'(m_p1 / 10), 4'(m_p1 % 10), 4'(m_p2 / 10), 4'(m_p2 % 10),
            2'(m_goal), m_freeze, m_over, 2'(m_winner)};
  endfunction

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_goal = 0; m_winner = 0; m_frames_left = 0;
    m_freeze = 0; m_over = 0; m_in_banner = 0; m_prev1 = 0; m_prev2 = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit t, input bit ng);
    bit e1, e2;
    e1 = a && !m_prev1;
    e2 = b && !m_prev2;
    m_prev1 = a;
    m_prev2 = b;
    if (ng) begin
      m_p1 = 0; m_p2 = 0; m_goal = 0; m_winner = 0;
      m_freeze = 0; m_over = 0; m_in_banner = 0;
    end else if (m_over) begin
      // nothing changes until new game
    end else if (m_in_banner) begin
      if (t) begin
        m_frames_left--;
        if (m_frames_left == 0) begin
          m_in_banner = 0;
          if (m_p1 == WIN || m_p2 == WIN) begin
            m_over = 1;
            m_winner = m_goal;
          end else begin
            m_freeze = 0;
          end
          m_goal = 0;
        end
      end
    end else if (e1 || e2) begin
      if (e1) begin
        m_p1 = (m_p1 < 99) ? m_p1 + 1 : 99;
        m_goal = 1;
      end else begin
        m_p2 = (m_p2 < 99) ? m_p2 + 1 : 99;
        m_goal = 2;
      end
      m_freeze = 1;
      m_in_banner = 1;
      m_frames_left = GF;
    end
  endtask

  // Drive one clock of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit a, input bit b, input bit t, input bit ng);
    p1_scored = a; p2_scored = b; refresh_tick = t; new_game = ng;
    @(posedge clk);
    model_step(a, b, t, ng);
    #1;
  endtask

  task automatic do_reset();
    p1_scored = 0; p2_scored = 0; refresh_tick = 0; new_game = 0;
    reset_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (dut_vec !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, 22'd0);
    end
  endtask

  task automatic test_single_goal();
    cyc(1, 0, 0, 0);
    n_vec++;
    if ({p1_dig1, p1_dig0, goal, freeze} !== {4'd0, 4'd1, 2'b01, 1'b1}) begin
      n_bad++;
      $display("FAIL single_goal_start: got %h/%h goal %b frz %b expected 0/1 01 1",
               p1_dig1, p1_dig0, goal, freeze);
    end
    cyc(0, 0, 0, 0);
    for (int i = 0; i < GF; i++) begin
      n_vec++;
      if (goal !== 2'b01 || freeze !== 1'b1) begin
        n_bad++;
        $display("FAIL banner_hold tick %0d: goal %b frz %b expected 01 1", i, goal, freeze);
      end
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    n_vec++;
    if (goal !== 2'b00 || freeze !== 1'b0 || dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL banner_end: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_win();
    cyc(0, 0, 0, 1);
    for (int g = 1; g <= WIN; g++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL win_goal %0d: got %h expected %h", g, dut_vec, exp_vec());
      end
      if (g == 9) begin
        n_vec++;
        if ({p1_dig1, p1_dig0} !== 8'h09) begin
          n_bad++;
          $display("FAIL score_nine: got %h%h expected 09", p1_dig1, p1_dig0);
        end
      end
      if (g == 10) begin
        n_vec++;
        if ({p1_dig1, p1_dig0} !== 8'h10) begin
          n_bad++;
          $display("FAIL score_ten: got %h%h expected 10", p1_dig1, p1_dig0);
        end
      end
      for (int i = 0; i < GF; i++) cyc(0, 0, 1, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL win_banner %0d: got %h expected %h", g, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if ({game_over, winner, freeze, goal} !== {1'b1, 2'b01, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL game_over: got over %b win %b frz %b goal %b expected 1 01 1 00",
               game_over, winner, freeze, goal);
    end
  endtask

  task automatic test_over_ignore();
    for (int i = 0; i < 20; i++) begin
      cyc(i[0], ~i[0], 1, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL over_hold %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    cyc(0, 0, 0, 1);
    n_vec++;
    if (dut_vec !== 22'd0) begin
      n_bad++;
      $display("FAIL new_game_over: got %h expected %h", dut_vec, 22'd0);
    end
    cyc(0, 1, 0, 0);
    n_vec++;
    if (goal !== 2'b10 || p2_dig0 !== 4'd1) begin
      n_bad++;
      $display("FAIL play_after_new_game: goal %b p2 %h expected 10 1", goal, p2_dig0);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_simultaneous();
    cyc(1, 1, 0, 0);
    n_vec++;
    if ({p1_dig0, p2_dig0, goal} !== {4'd1, 4'd0, 2'b01}) begin
      n_bad++;
      $display("FAIL simultaneous: got p1 %h p2 %h goal %b expected 1 0 01",
               p1_dig0, p2_dig0, goal);
    end
    // p2 held high through the banner and beyond: no credit.
    for (int i = 0; i < GF; i++) cyc(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    n_vec++;
    if ({p2_dig0, goal, freeze} !== {4'd0, 2'b00, 1'b0} || dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL held_level: got %h expected %h", dut_vec, exp_vec());
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    n_vec++;
    if ({p2_dig0, goal} !== {4'd1, 2'b10}) begin
      n_bad++;
      $display("FAIL re_rise: got p2 %h goal %b expected 1 10", p2_dig0, goal);
    end
    // P2 event during banner ignored
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    n_vec++;
    if ({p1_dig0, p2_dig0, goal} !== {4'd1, 4'd1, 2'b10}) begin
      n_bad++;
      $display("FAIL goal_ignore: got p1 %h p2 %h goal %b expected 1 1 10",
               p1_dig0, p2_dig0, goal);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_new_game_coincident();
    cyc(1, 0, 0, 1);
    n_vec++;
    if (dut_vec !== 22'd0) begin
      n_bad++;
      $display("FAIL ng_coincident: got %h expected %h", dut_vec, 22'd0);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_banner();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    n_vec++;
    if (goal !== 2'b01) begin
      n_bad++;
      $display("FAIL pre_reset_banner: goal %b expected 01", goal);
    end
    do_reset();
    n_vec++;
    if (dut_vec !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_mid_banner: got %h expected %h", dut_vec, 22'd0);
    end
    cyc(1, 0, 0, 0);
    n_vec++;
    if ({p1_dig0, goal} !== {4'd1, 2'b01}) begin
      n_bad++;
      $display("FAIL play_after_reset: p1 %h goal %b expected 1 01", p1_dig0, goal);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit a, b, t, ng;
    for (int i = 0; i < 12000; i++) begin
      a  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 1) == 0);
      ng = ($urandom_range(0, 2999) == 0) || (m_over && $urandom_range(0, 49) == 0);
      cyc(a, b, t, ng);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_goal();
    test_win();
    test_over_ignore();
    test_simultaneous();
    test_new_game_coincident();
    test_reset_mid_banner();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
